// File: rtl/sad_best_sel.sv
// Motion-search issue controller and minimum-SAD collector for the 16x16 SAD engine.
// Issues one strobe per candidate, tracks the best result and drains in-flight results before done.
module sad_best_sel #(
   parameter int IDX_W = 6,
   parameter int SAD_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W:0]   cand_cnt,
   input  logic             thr_en,
   input  logic [SAD_W-1:0] thr,
   output logic             cal_en,
   output logic [IDX_W-1:0] cand_idx,
   input  logic [SAD_W-1:0] sad,
   input  logic             sad_vld,
   output logic             busy,
   output logic             done,
   output logic [SAD_W-1:0] best_sad,
   output logic [IDX_W-1:0] best_idx,
   output logic             early_hit
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [IDX_W:0] CNT_ZERO = {(IDX_W+1){1'b0}};
   localparam logic [IDX_W:0] CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

   state_t             state_r;
   logic [IDX_W:0]     iss_cnt_r;
   logic [IDX_W:0]     rx_cnt_r;
   logic [IDX_W:0]     cnt_r;
   logic               thr_en_r;
   logic [SAD_W-1:0]   thr_r;

   logic               take_s;
   logic               hit_s;
   logic               better_s;
   logic [IDX_W:0]     rx_nxt_s;

   // Result acceptance, threshold hit and new-minimum detection for the current beat
   always_comb begin
      take_s   = 1'b0;
      hit_s    = 1'b0;
      better_s = 1'b0;
      rx_nxt_s = rx_cnt_r;
      if ((state_r == ISSUE || state_r == DRAIN) && sad_vld && (rx_cnt_r != iss_cnt_r)) begin
         take_s   = 1'b1;
         hit_s    = thr_en_r && (sad <= thr_r);
         better_s = (sad < best_sad);
         rx_nxt_s = rx_cnt_r + CNT_ONE;
      end else begin
         take_s   = 1'b0;
      end
   end

   // Search FSM with registered outputs; iss_cnt_r includes the strobe currently on cal_en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         iss_cnt_r <= CNT_ZERO;
         rx_cnt_r  <= CNT_ZERO;
         cnt_r     <= CNT_ZERO;
         thr_en_r  <= 1'b0;
         thr_r     <= {SAD_W{1'b0}};
         cal_en    <= 1'b0;
         cand_idx  <= {IDX_W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         best_sad  <= {SAD_W{1'b1}};
         best_idx  <= {IDX_W{1'b0}};
         early_hit <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done   <= 1'b0;
               cal_en <= 1'b0;
               if (start) begin
                  cnt_r     <= cand_cnt;
                  thr_en_r  <= thr_en;
                  thr_r     <= thr;
                  rx_cnt_r  <= CNT_ZERO;
                  early_hit <= 1'b0;
                  best_sad  <= {SAD_W{1'b1}};
                  best_idx  <= {IDX_W{1'b0}};
                  busy      <= 1'b1;
                  cand_idx  <= {IDX_W{1'b0}};
                  if (cand_cnt == CNT_ZERO) begin
                     iss_cnt_r <= CNT_ZERO;
                     done      <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     iss_cnt_r <= CNT_ONE;
                     cal_en    <= 1'b1;
                     state_r   <= ISSUE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               if (hit_s || (iss_cnt_r == cnt_r)) begin
                  cal_en  <= 1'b0;
                  state_r <= DRAIN;
               end else begin
                  cal_en    <= 1'b1;
                  cand_idx  <= iss_cnt_r[IDX_W-1:0];
                  iss_cnt_r <= iss_cnt_r + CNT_ONE;
               end
            end
            DRAIN: begin
               cal_en <= 1'b0;
               // compare against the post-beat count so done lands right after the final result
               if (rx_nxt_s == iss_cnt_r) begin
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= DRAIN;
               end
            end
            DONE: begin
               cal_en  <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               cal_en  <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase

         if (take_s) begin
            rx_cnt_r <= rx_nxt_s;
            if (better_s) begin
               best_sad <= sad;
               best_idx <= rx_cnt_r[IDX_W-1:0];
            end
            if (hit_s) begin
               early_hit <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sad_best_sel.sv
// Directed self-checking bench for sad_best_sel with a 6-cycle SAD engine model.
module tb_sad_best_sel;
   localparam int IDX_W = 6;
   localparam int SAD_W = 16;
   localparam int LAT   = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [IDX_W:0]   cand_cnt = '0;
   logic             thr_en = 1'b0;
   logic [SAD_W-1:0] thr = '0;
   logic             cal_en;
   logic [IDX_W-1:0] cand_idx;
   logic [SAD_W-1:0] sad;
   logic             sad_vld;
   logic             busy;
   logic             done;
   logic [SAD_W-1:0] best_sad;
   logic [IDX_W-1:0] best_idx;
   logic             early_hit;

   int tests = 0;
   int fails = 0;

   logic [SAD_W-1:0] sad_tab [64];
   logic [LAT-1:0]   pipe_vld;
   logic [IDX_W-1:0] pipe_idx [LAT];
   logic             inj_vld = 1'b0;
   logic [SAD_W-1:0] inj_sad = '0;

   int               strobe_cnt = 0;
   int               done_cnt = 0;
   logic [IDX_W-1:0] strobe_log [256];

   sad_best_sel #(.IDX_W(IDX_W), .SAD_W(SAD_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cand_cnt(cand_cnt), .thr_en(thr_en), .thr(thr),
      .cal_en(cal_en), .cand_idx(cand_idx), .sad(sad), .sad_vld(sad_vld), .busy(busy),
      .done(done), .best_sad(best_sad), .best_idx(best_idx), .early_hit(early_hit)
   );

   always #5 clk = ~clk;

   // engine model: strobe in cycle k returns its table value in cycle k+LAT
   always @(posedge clk) begin
      pipe_vld <= {pipe_vld[LAT-2:0], cal_en};
      pipe_idx[0] <= cand_idx;
      for (int i = 1; i < LAT; i++) pipe_idx[i] <= pipe_idx[i-1];
   end
   assign sad_vld = inj_vld | (pipe_vld[LAT-1] === 1'b1);
   assign sad     = inj_vld ? inj_sad : sad_tab[pipe_idx[LAT-1]];

   always @(negedge clk) begin
      if (cal_en === 1'b1) begin
         strobe_log[strobe_cnt % 256] = cand_idx;
         strobe_cnt++;
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic run_search(input int n, input logic te, input logic [SAD_W-1:0] th,
                             input int pa, input int pb, output int lat, output logic bsy);
      @(negedge clk);
      start = 1'b1; cand_cnt = n[IDX_W:0]; thr_en = te; thr = th;
      @(negedge clk);
      start = 1'b0; lat = 1;
      while (done !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
         if (lat == pa || lat == pb) begin
            start = 1'b1; cand_cnt = 7'd2;
         end else begin
            start = 1'b0;
         end
      end
      bsy = busy;
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         start = 1'($urandom); cand_cnt = 7'($urandom); thr_en = 1'($urandom);
         thr = 16'($urandom); inj_vld = 1'($urandom); inj_sad = 16'($urandom);
      end
      @(negedge clk);
      tests++; if (cal_en !== 1'b0) begin fails++; $display("FAIL rst_cal_en got %b exp 0", cal_en); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
      tests++; if (best_sad !== 16'hFFFF) begin fails++; $display("FAIL rst_best_sad got %h exp ffff", best_sad); end
      tests++; if (best_idx !== 6'd0) begin fails++; $display("FAIL rst_best_idx got %0d exp 0", best_idx); end
      tests++; if (early_hit !== 1'b0) begin fails++; $display("FAIL rst_early_hit got %b exp 0", early_hit); end
      tests++; if (cand_idx !== 6'd0) begin fails++; $display("FAIL rst_cand_idx got %0d exp 0", cand_idx); end
      start = 1'b0; inj_vld = 1'b0; thr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_basic();
      int s0, d0, lat; logic bsy;
      sad_tab[0] = 16'd300; sad_tab[1] = 16'd120; sad_tab[2] = 16'd500; sad_tab[3] = 16'd120;
      s0 = strobe_cnt; d0 = done_cnt;
      run_search(4, 1'b0, 16'd0, 0, 0, lat, bsy);
      tests++; if (strobe_cnt - s0 !== 4) begin fails++; $display("FAIL basic_strobes got %0d exp 4", strobe_cnt - s0); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (strobe_log[(s0 + i) % 256] !== 6'(i)) begin
            fails++; $display("FAIL basic_idx%0d got %0d exp %0d", i, strobe_log[(s0 + i) % 256], i);
         end
      end
      tests++; if (lat !== 11) begin fails++; $display("FAIL basic_done_lat got %0d exp 11", lat); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt - d0); end
      tests++; if (bsy !== 1'b1) begin fails++; $display("FAIL basic_busy_at_done got %b exp 1", bsy); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b exp 0", busy); end
      tests++; if (best_sad !== 16'd120) begin fails++; $display("FAIL basic_best_sad got %0d exp 120", best_sad); end
      tests++; if (best_idx !== 6'd1) begin fails++; $display("FAIL basic_best_idx got %0d exp 1", best_idx); end
      tests++; if (early_hit !== 1'b0) begin fails++; $display("FAIL basic_early_hit got %b exp 0", early_hit); end
   endtask

   task automatic test_zero();
      int s0, lat; logic bsy;
      s0 = strobe_cnt;
      run_search(0, 1'b0, 16'd0, 0, 0, lat, bsy);
      tests++; if (lat !== 1) begin fails++; $display("FAIL zero_done_lat got %0d exp 1", lat); end
      tests++; if (strobe_cnt - s0 !== 0) begin fails++; $display("FAIL zero_strobes got %0d exp 0", strobe_cnt - s0); end
      tests++; if (best_sad !== 16'hFFFF) begin fails++; $display("FAIL zero_best_sad got %h exp ffff", best_sad); end
      tests++; if (best_idx !== 6'd0) begin fails++; $display("FAIL zero_best_idx got %0d exp 0", best_idx); end
   endtask

   task automatic test_early_exit();
      int s0, d0, lat; logic bsy;
      for (int i = 0; i < 64; i++) sad_tab[i] = 16'd200;
      sad_tab[5] = 16'd40; sad_tab[7] = 16'd10;
      s0 = strobe_cnt; d0 = done_cnt;
      run_search(64, 1'b1, 16'd50, 0, 0, lat, bsy);
      tests++; if (strobe_cnt - s0 !== 12) begin fails++; $display("FAIL early_strobes got %0d exp 12", strobe_cnt - s0); end
      tests++; if (strobe_log[(s0 + 11) % 256] !== 6'd11) begin fails++; $display("FAIL early_last_idx got %0d exp 11", strobe_log[(s0 + 11) % 256]); end
      tests++; if (lat !== 19) begin fails++; $display("FAIL early_done_lat got %0d exp 19", lat); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL early_done_cnt got %0d exp 1", done_cnt - d0); end
      tests++; if (best_sad !== 16'd10) begin fails++; $display("FAIL early_best_sad got %0d exp 10", best_sad); end
      tests++; if (best_idx !== 6'd7) begin fails++; $display("FAIL early_best_idx got %0d exp 7", best_idx); end
      tests++; if (early_hit !== 1'b1) begin fails++; $display("FAIL early_hit got %b exp 1", early_hit); end
   endtask

   task automatic test_idle_sad();
      @(negedge clk);
      inj_sad = 16'd1; inj_vld = 1'b1;
      repeat (3) @(negedge clk);
      inj_vld = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (best_sad !== 16'd10) begin fails++; $display("FAIL idle_best_sad got %0d exp 10", best_sad); end
      tests++; if (best_idx !== 6'd7) begin fails++; $display("FAIL idle_best_idx got %0d exp 7", best_idx); end
      tests++; if (early_hit !== 1'b1) begin fails++; $display("FAIL idle_early_hit got %b exp 1", early_hit); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      int s0, d0, lat; logic bsy;
      for (int i = 0; i < 64; i++) sad_tab[i] = 16'hFFFF;
      s0 = strobe_cnt; d0 = done_cnt;
      run_search(64, 1'b0, 16'd0, 5, 68, lat, bsy);
      repeat (4) @(negedge clk);
      tests++; if (strobe_cnt - s0 !== 64) begin fails++; $display("FAIL b2b_strobes got %0d exp 64", strobe_cnt - s0); end
      tests++; if (strobe_log[(s0 + 63) % 256] !== 6'd63) begin fails++; $display("FAIL b2b_last_idx got %0d exp 63", strobe_log[(s0 + 63) % 256]); end
      tests++; if (lat !== 71) begin fails++; $display("FAIL b2b_done_lat got %0d exp 71", lat); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL b2b_done_cnt got %0d exp 1", done_cnt - d0); end
      tests++; if (best_sad !== 16'hFFFF) begin fails++; $display("FAIL b2b_best_sad got %h exp ffff", best_sad); end
      tests++; if (best_idx !== 6'd0) begin fails++; $display("FAIL b2b_best_idx got %0d exp 0", best_idx); end
      tests++; if (early_hit !== 1'b0) begin fails++; $display("FAIL b2b_early_hit got %b exp 0", early_hit); end
   endtask

   task automatic test_rst_mid();
      int s0, d0, lat; logic bsy;
      for (int i = 0; i < 64; i++) sad_tab[i] = 16'd100;
      s0 = strobe_cnt;
      @(negedge clk);
      start = 1'b1; cand_cnt = 7'd64; thr_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 50 && (strobe_cnt - s0) < 10; k++) begin
         @(negedge clk); #1;
      end
      tests++; if (strobe_cnt - s0 < 10) begin fails++; $display("FAIL mid_reach10 got %0d exp 10", strobe_cnt - s0); end
      tests++; if (best_sad !== 16'd100) begin fails++; $display("FAIL mid_pre_best got %0d exp 100", best_sad); end
      rst = 1'b1;
      #1;
      tests++; if (cal_en !== 1'b0) begin fails++; $display("FAIL mid_cal_en got %b exp 0", cal_en); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy); end
      tests++; if (best_sad !== 16'hFFFF) begin fails++; $display("FAIL mid_best_sad got %h exp ffff", best_sad); end
      tests++; if (best_idx !== 6'd0) begin fails++; $display("FAIL mid_best_idx got %0d exp 0", best_idx); end
      tests++; if (cand_idx !== 6'd0) begin fails++; $display("FAIL mid_cand_idx got %0d exp 0", cand_idx); end
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      sad_tab[0] = 16'd7; sad_tab[1] = 16'd3; sad_tab[2] = 16'd9; sad_tab[3] = 16'd3;
      s0 = strobe_cnt; d0 = done_cnt;
      run_search(4, 1'b0, 16'd0, 0, 0, lat, bsy);
      tests++; if (strobe_cnt - s0 !== 4) begin fails++; $display("FAIL post_strobes got %0d exp 4", strobe_cnt - s0); end
      tests++; if (lat !== 11) begin fails++; $display("FAIL post_done_lat got %0d exp 11", lat); end
      tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL post_done_cnt got %0d exp 1", done_cnt - d0); end
      tests++; if (best_sad !== 16'd3) begin fails++; $display("FAIL post_best_sad got %0d exp 3", best_sad); end
      tests++; if (best_idx !== 6'd1) begin fails++; $display("FAIL post_best_idx got %0d exp 1", best_idx); end
      tests++; if (early_hit !== 1'b0) begin fails++; $display("FAIL post_early_hit got %b exp 0", early_hit); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) sad_tab[i] = 16'd0;
      test_reset();
      test_basic();
      test_zero();
      test_early_exit();
      test_idle_sad();
      test_back_to_back();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
